// File: rtl/mrf_tx_scheduler.sv
// mrf_tx_scheduler
//
// Sequences the MRF event-link transmit datapath on the transceiver TX clock.
// After link_ready rises, a burst of ALIGN_WORDS K28.5 comma words is sent.
// The block then enters RUN, where one word in every COMMA_PERIOD is a comma
// and the remaining slots carry event codes. Codes are picked round-robin from
// N_REQ requesters, or the null event 8'h00 is sent when nobody is requesting.
// The distributed-bus byte rides in the high byte of every non-idle word.
//
// Ports:
//   aclk       transceiver TX user clock, rising edge
//   aresetn    asynchronous active-low reset
//   link_ready TX reset done from the transceiver (synchronous to aclk)
//   req_valid  per-requester event request
//   req_code   event codes, requester i on bits [8*i+7:8*i]
//   req_ready  one-hot grant (combinational)
//   dbus_in    distributed-bus byte, sampled every cycle
//   tx_data    registered transceiver word {dbus, event/comma}
//   txcharisk  registered K-flags per byte
//   aligned    high while in RUN
//   ev_count   count of transmitted non-null events
//
// Optional feature: define MRF_TX_STATS_EN to build the event counter.
// Without it ev_count is tied to zero.

module mrf_tx_scheduler #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned COMMA_PERIOD = 8,
  parameter int unsigned ALIGN_WORDS  = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 link_ready,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_code,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [7:0]           dbus_in,
  output logic [15:0]          tx_data,
  output logic [1:0]           txcharisk,
  output logic                 aligned,
  output logic [31:0]          ev_count
);

  localparam int          NReq = int'(N_REQ);
  localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CcW  = (COMMA_PERIOD > 1) ? $clog2(COMMA_PERIOD) : 1;
  localparam int unsigned AcW  = (ALIGN_WORDS > 1) ? $clog2(ALIGN_WORDS) : 1;

  localparam logic [CcW-1:0] CommaLast = CcW'(COMMA_PERIOD - 1);
  localparam logic [AcW-1:0] AlignLast = AcW'(ALIGN_WORDS - 1);
  localparam logic [7:0]     K28p5     = 8'hBC;

  typedef enum logic [1:0] {StLinkDown, StAlign, StRun} state_e;

  state_e            st_q;
  logic [PtrW-1:0]   ptr_q;
  logic [PtrW-1:0]   ptr_nxt;
  logic [CcW-1:0]    cc_q;
  logic [AcW-1:0]    ac_q;
  logic [15:0]       tx_data_q;
  logic [1:0]        txk_q;

  logic [N_REQ-1:0]  pick;
  logic              pick_any;
  logic [7:0]        pick_code;
  logic              comma_slot;
  logic              grant_en;

  // Round-robin pick: scan offsets 0..N_REQ-1 from the pointer, first valid
  // requester wins. Both loops are bounded by constants so this unrolls cleanly.
  always_comb begin
    pick     = '0;
    pick_any = 1'b0;
    for (int k = 0; k < NReq; k++) begin
      for (int i = 0; i < NReq; i++) begin
        if (!pick_any && req_valid[i] && (i == ((int'(ptr_q) + k) % NReq))) begin
          pick[i] = 1'b1;
        end
      end
      if (|pick) begin
        pick_any = 1'b1;
      end
    end

    pick_code = 8'h00;
    ptr_nxt   = ptr_q;
    for (int i = 0; i < NReq; i++) begin
      if (pick[i]) begin
        pick_code = req_code[8*i +: 8];
        ptr_nxt   = PtrW'((i + 1) % NReq);
      end
    end
  end

  assign comma_slot = (cc_q == CommaLast);
  // A dropping link_ready suppresses the grant in the same cycle so that no
  // requester believes its code was sent when the link is going down.
  assign grant_en   = (st_q == StRun) && link_ready && !comma_slot;
  assign req_ready  = grant_en ? pick : '0;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      st_q      <= StLinkDown;
      ptr_q     <= '0;
      cc_q      <= '0;
      ac_q      <= '0;
      tx_data_q <= 16'h0000;
      txk_q     <= 2'b00;
    end else begin
      unique case (st_q)
        StLinkDown: begin
          tx_data_q <= 16'h0000;
          txk_q     <= 2'b00;
          ptr_q     <= '0;
          cc_q      <= '0;
          ac_q      <= '0;
          if (link_ready) begin
            st_q <= StAlign;
          end
        end

        StAlign: begin
          if (!link_ready) begin
            st_q      <= StLinkDown;
            tx_data_q <= 16'h0000;
            txk_q     <= 2'b00;
            ptr_q     <= '0;
            cc_q      <= '0;
            ac_q      <= '0;
          end else begin
            tx_data_q <= {dbus_in, K28p5};
            txk_q     <= 2'b01;
            if (ac_q == AlignLast) begin
              st_q <= StRun;
              cc_q <= '0;
            end else begin
              ac_q <= ac_q + AcW'(1);
            end
          end
        end

        StRun: begin
          if (!link_ready) begin
            st_q      <= StLinkDown;
            tx_data_q <= 16'h0000;
            txk_q     <= 2'b00;
            ptr_q     <= '0;
            cc_q      <= '0;
            ac_q      <= '0;
          end else if (comma_slot) begin
            tx_data_q <= {dbus_in, K28p5};
            txk_q     <= 2'b01;
            cc_q      <= '0;
          end else begin
            // pick_code is 8'h00 when nobody requests, which is the null event.
            tx_data_q <= {dbus_in, pick_code};
            txk_q     <= 2'b00;
            cc_q      <= cc_q + CcW'(1);
            if (pick_any) begin
              ptr_q <= ptr_nxt;
            end
          end
        end

        default: begin
          st_q      <= StLinkDown;
          tx_data_q <= 16'h0000;
          txk_q     <= 2'b00;
        end
      endcase
    end
  end

  assign tx_data   = tx_data_q;
  assign txcharisk = txk_q;
  assign aligned   = (st_q == StRun);

`ifdef MRF_TX_STATS_EN
  logic [31:0] ev_q;

  // Only reset clears the counter; link loss leaves it intact.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ev_q <= 32'h0;
    end else if (grant_en && pick_any && (pick_code != 8'h00)) begin
      ev_q <= ev_q + 32'd1;
    end
  end

  assign ev_count = ev_q;
`else
  assign ev_count = 32'h0;
`endif

endmodule

// File: tb/tb_mrf_tx_scheduler.sv
module tb_mrf_tx_scheduler;

  localparam int NReq = 4;
  localparam int CP   = 8;
  localparam int AW   = 16;

`ifdef MRF_TX_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic                aclk = 1'b0;
  logic                aresetn;
  logic                link_ready;
  logic [NReq-1:0]     req_valid;
  logic [8*NReq-1:0]   req_code;
  logic [NReq-1:0]     req_ready;
  logic [7:0]          dbus_in;
  logic [15:0]         tx_data;
  logic [1:0]          txcharisk;
  logic                aligned;
  logic [31:0]         ev_count;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: link mode (0 down, 1 align, 2 run), words sent in the
  // current align burst, words sent since RUN began, round-robin pointer.
  int          m_mode;
  int          m_align_n;
  int          m_run_n;
  int          m_ptr;
  logic [31:0] m_ev;

  always #5 aclk = ~aclk;

  mrf_tx_scheduler #(
    .N_REQ        (NReq),
    .COMMA_PERIOD (CP),
    .ALIGN_WORDS  (AW)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .link_ready (link_ready),
    .req_valid  (req_valid),
    .req_code   (req_code),
    .req_ready  (req_ready),
    .dbus_in    (dbus_in),
    .tx_data    (tx_data),
    .txcharisk  (txcharisk),
    .aligned    (aligned),
    .ev_count   (ev_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode    = 0;
    m_align_n = 0;
    m_run_n   = 0;
    m_ptr     = 0;
    m_ev      = 32'h0;
  endtask

  task automatic drive(input logic lr, input logic [NReq-1:0] v, input logic [8*NReq-1:0] c);
    link_ready = lr;
    req_valid  = v;
    req_code   = c;
    dbus_in    = 8'($urandom);
  endtask

  // One clock: check combinational grant and aligned, advance the model,
  // then check the registered word after the edge.
  task automatic cycle();
    logic [NReq-1:0] er;
    logic [15:0]     w;
    logic [1:0]      k;
    logic [7:0]      code;
    int              j;
    bit              found;
    #1;
    chk("aligned", 32'(aligned), 32'(m_mode == 2));
    er = '0;
    w  = 16'h0000;
    k  = 2'b00;
    case (m_mode)
      0: begin
        if (link_ready) begin
          m_mode    = 1;
          m_align_n = 0;
        end
      end
      1: begin
        if (!link_ready) begin
          m_mode = 0;
          m_ptr  = 0;
        end else begin
          w = {dbus_in, 8'hBC};
          k = 2'b01;
          m_align_n++;
          if (m_align_n == AW) begin
            m_mode  = 2;
            m_run_n = 0;
          end
        end
      end
      default: begin
        if (!link_ready) begin
          m_mode = 0;
          m_ptr  = 0;
        end else if ((m_run_n % CP) == CP - 1) begin
          w = {dbus_in, 8'hBC};
          k = 2'b01;
          m_run_n++;
        end else begin
          found = 1'b0;
          code  = 8'h00;
          for (int o = 0; o < NReq; o++) begin
            j = (m_ptr + o) % NReq;
            if (!found && req_valid[j]) begin
              found = 1'b1;
              er[j] = 1'b1;
              code  = req_code[8*j +: 8];
              m_ptr = (j + 1) % NReq;
            end
          end
          if (StatsEn && found && code != 8'h00) m_ev = m_ev + 32'd1;
          w = {dbus_in, code};
          m_run_n++;
        end
      end
    endcase
    chk("req_ready", 32'(req_ready), 32'(er));
    @(posedge aclk);
    #1;
    chk("tx_data", 32'(tx_data), 32'(w));
    chk("txcharisk", 32'(txcharisk), 32'(k));
    chk("ev_count", ev_count, m_ev);
  endtask

  initial begin
    logic [8*NReq-1:0] rc;
    logic              lr;

    // Reset state, with requests pending to prove no grant leaks out.
    aresetn = 1'b0;
    drive(1'b0, '1, 32'h44332211);
    model_reset();
    @(posedge aclk);
    #1;
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_txcharisk", 32'(txcharisk), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_aligned", 32'(aligned), 32'h0);
    chk("rst_ev_count", ev_count, 32'h0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;

    // Alignment burst, then idle RUN with null events and periodic commas.
    for (int n = 0; n < 45; n++) begin
      drive(1'b1, '0, '0);
      cycle();
    end

    // Sole requester with a held code.
    for (int n = 0; n < 24; n++) begin
      drive(1'b1, 4'b0001, 32'h0000007A);
      cycle();
    end

    // All requesters busy: rotation across comma slots.
    for (int n = 0; n < 24; n++) begin
      drive(1'b1, 4'b1111, 32'h44332211);
      cycle();
    end

    // Random requests, codes (some null) and occasional link loss.
    for (int n = 0; n < 300; n++) begin
      rc = {$urandom, $urandom};
      for (int b = 0; b < NReq; b++) begin
        if ($urandom_range(3) == 0) rc[8*b +: 8] = 8'h00;
      end
      lr = ($urandom_range(63) != 0);
      drive(lr, NReq'($urandom), rc);
      cycle();
    end

    // Ensure RUN, then drop the link during a granted word and re-align.
    for (int n = 0; n < 20; n++) begin
      drive(1'b1, 4'b1111, 32'h44332211);
      cycle();
    end
    drive(1'b0, 4'b1111, 32'h44332211);
    cycle();
    drive(1'b0, 4'b1111, 32'h44332211);
    cycle();
    for (int n = 0; n < 30; n++) begin
      drive(1'b1, 4'b1111, 32'h44332211);
      cycle();
    end

    // Counted versus null codes from a sole requester.
    for (int n = 0; n < 11; n++) begin
      drive(1'b1, 4'b0100, 32'h00010000);
      cycle();
    end
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, 4'b0100, 32'h00000000);
      cycle();
    end

    // Asynchronous reset mid-stream clears everything including the counter.
    #2;
    aresetn = 1'b0;
    model_reset();
    #1;
    chk("arst_tx_data", 32'(tx_data), 32'h0);
    chk("arst_aligned", 32'(aligned), 32'h0);
    chk("arst_ev_count", ev_count, 32'h0);
    chk("arst_req_ready", 32'(req_ready), 32'h0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    for (int n = 0; n < 20; n++) begin
      drive(1'b1, 4'b1000, 32'h5A000000);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
